// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: sequencer state codes and default width.
// Both the divider and the shift/add multiplier controls can import this.
package arith_pkg;

    localparam int W_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_SHIFT = 3'b001,
        S_SUB   = 3'b010,
        S_DONE  = 3'b011
    } state_t;

endpackage

// File: rtl/div_datapath.sv
// Restoring-divider datapath: A/Q/M registers, (W+1)-bit subtractor,
// iteration counter and the held quotient/remainder result registers.
module div_datapath
    import arith_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic         sub_step,
    input  logic         commit,
    input  logic         load_zero,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         borrow,
    output logic         last,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(W + 1);

    logic [W:0]    r_a;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_m;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_quot;
    logic [W-1:0]  r_rem;
    logic          r_dbz;

    logic [W+1:0]  w_diff;
    logic [W:0]    w_a_new;
    logic [W-1:0]  w_q_new;

    // Extra top bit of the difference acts as the borrow flag.
    assign w_diff  = {1'b0, r_a} - {2'b00, r_m};
    assign borrow  = w_diff[W+1];
    assign w_a_new = borrow ? r_a : w_diff[W:0];
    assign w_q_new = {r_q[W-1:1], ~borrow};
    assign last    = (r_count == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_count <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            if (load) begin
                r_a     <= '0;
                r_q     <= dividend;
                r_m     <= divisor;
                r_count <= CW'(W);
                r_dbz   <= 1'b0;
            end else if (shift) begin
                {r_a, r_q} <= {r_a[W-1:0], r_q, 1'b0};
            end else if (sub_step) begin
                r_a     <= w_a_new;
                r_q     <= w_q_new;
                r_count <= r_count - CW'(1);
            end
            if (commit) begin
                r_quot <= w_q_new;
                r_rem  <= w_a_new[W-1:0];
            end
            if (load_zero) begin
                r_quot <= '1;
                r_rem  <= dividend;
                r_dbz  <= 1'b1;
            end
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: start/done control FSM driving
// div_datapath, one quotient bit per shift/subtract pair.
module restoring_divider
    import arith_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    state_t r_state;
    state_t w_next;

    logic w_load;
    logic w_shift;
    logic w_sub_step;
    logic w_commit;
    logic w_load_zero;
    logic w_borrow;
    logic w_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_sub_step  = 1'b0;
        w_commit    = 1'b0;
        w_load_zero = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        w_load = 1'b1;
                        w_next = S_SHIFT;
                    end else begin
                        w_load_zero = 1'b1;
                        w_next      = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                busy    = 1'b1;
                w_shift = 1'b1;
                w_next  = S_SUB;
            end
            S_SUB: begin
                busy       = 1'b1;
                w_sub_step = 1'b1;
                if (w_last) begin
                    w_commit = 1'b1;
                    w_next   = S_DONE;
                end else begin
                    w_next = S_SHIFT;
                end
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    div_datapath #(.W(W)) u_dp (
        .clk         (clk),
        .reset       (reset),
        .load        (w_load),
        .shift       (w_shift),
        .sub_step    (w_sub_step),
        .commit      (w_commit),
        .load_zero   (w_load_zero),
        .dividend    (dividend),
        .divisor     (divisor),
        .borrow      (w_borrow),
        .last        (w_last),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

endmodule
